// File: rtl/iic_reg_seq_if.sv
// rtl/iic_reg_seq_if.sv - request/response bundle between the register sequencer and the iic master
interface iic_reg_seq_if #(
    parameter int ADDR_W = 16
);
    logic [7:0]        device_id;
    logic              iic_trig;
    logic              w_r;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data_in;
    logic              busy;
    logic [7:0]        data_out;

    modport master (
        output device_id, iic_trig, w_r, addr, data_in,
        input  busy, data_out
    );

    modport slave (
        input  device_id, iic_trig, w_r, addr, data_in,
        output busy, data_out
    );
endinterface

// File: rtl/iic_reg_seq.sv
// rtl/iic_reg_seq.sv - table-driven I2C register init sequencer with probe, verify, delay and status polling
module iic_reg_seq #(
    parameter logic [7:0]        DEV_ID      = 8'hB2,
    parameter int                ADDR_W      = 16,
    parameter int                IDX_W       = 6,
    parameter logic [ADDR_W-1:0] PROBE_ADDR  = ADDR_W'(16'h0003),
    parameter logic [7:0]        PROBE_DATA  = 8'h5A,
    parameter int                MAX_RETRY   = 3,
    parameter int                RETRY_DLY   = 1000,
    parameter int                TIMEOUT     = 200000,
    parameter int                DLY_UNIT    = 1000,
    parameter logic [ADDR_W-1:0] POLL_ADDR   = ADDR_W'(16'h0502),
    parameter int                POLL_PERIOD = 1000000,
    parameter bit                AUTO_START  = 1'b1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    output logic [IDX_W-1:0]   rom_addr,
    input  logic [ADDR_W+9:0]  rom_data,
    iic_reg_seq_if.master      iic,
    output logic               init_over,
    output logic               init_err,
    output logic [IDX_W-1:0]   err_index,
    output logic [7:0]         poll_data,
    output logic               poll_valid
);

    localparam logic [31:0] TMO_LAST   = 32'((TIMEOUT     > 0) ? TIMEOUT - 1     : 0);
    localparam logic [31:0] RETRY_LAST = 32'((RETRY_DLY   > 0) ? RETRY_DLY - 1   : 0);
    localparam logic [31:0] DLY_LAST   = 32'((DLY_UNIT    > 0) ? DLY_UNIT - 1    : 0);
    localparam logic [31:0] POLL_LAST  = 32'((POLL_PERIOD > 0) ? POLL_PERIOD - 1 : 0);

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_VERIFY = 2'b01;
    localparam logic [1:0] OP_DELAY  = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE, S_PROBE_W, S_PROBE_R, S_RETRY, S_FETCH,
        S_EXEC, S_DELAY, S_DONE, S_POLL, S_ERROR
    } state_t;

    state_t              state;
    logic                busy_q;
    logic                issued;
    logic                fetch_wait;
    logic                run_req;
    logic                start_pend;
    logic [31:0]         tmr;
    logic [7:0]          retry_cnt;
    logic [ADDR_W+7:0]   dly_left;
    logic [7:0]          exp_data;

    logic [1:0]          op;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_data;
    logic                busy_fall;
    logic                probe_phase;
    logic                last_idx;

    assign op          = rom_data[ADDR_W+9:ADDR_W+8];
    assign r_addr      = rom_data[ADDR_W+7:8];
    assign r_data      = rom_data[7:0];
    assign busy_fall   = ~iic.busy & busy_q;
    assign probe_phase = (state == S_PROBE_W) || (state == S_PROBE_R);
    assign last_idx    = &rom_addr;
    assign iic.device_id = DEV_ID;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= S_IDLE;
            busy_q       <= 1'b0;
            issued       <= 1'b0;
            fetch_wait   <= 1'b0;
            run_req      <= AUTO_START;
            start_pend   <= 1'b0;
            tmr          <= '0;
            retry_cnt    <= '0;
            dly_left     <= '0;
            exp_data     <= '0;
            rom_addr     <= '0;
            iic.iic_trig <= 1'b0;
            iic.w_r      <= 1'b1;
            iic.addr     <= '0;
            iic.data_in  <= '0;
            init_over    <= 1'b0;
            init_err     <= 1'b0;
            err_index    <= '0;
            poll_data    <= '0;
            poll_valid   <= 1'b0;
        end else begin
            busy_q       <= iic.busy;
            iic.iic_trig <= 1'b0;
            poll_valid   <= 1'b0;
            if (state == S_POLL && start)
                start_pend <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (run_req || start) begin
                        run_req     <= 1'b0;
                        retry_cnt   <= '0;
                        iic.addr    <= PROBE_ADDR;
                        iic.data_in <= PROBE_DATA;
                        iic.w_r     <= 1'b1;
                        issued      <= 1'b0;
                        state       <= S_PROBE_W;
                    end
                end

                // Every bus transaction: trig one cycle after the request fields settle, then wait for busy_fall.
                S_PROBE_W, S_PROBE_R, S_EXEC, S_POLL: begin
                    if (!issued) begin
                        iic.iic_trig <= 1'b1;
                        issued       <= 1'b1;
                        tmr          <= '0;
                    end else if (busy_fall) begin
                        issued <= 1'b0;
                        case (state)
                            S_PROBE_W: begin
                                iic.w_r <= 1'b0;
                                state   <= S_PROBE_R;
                            end
                            S_PROBE_R: begin
                                if (iic.data_out == PROBE_DATA) begin
                                    iic.w_r    <= 1'b1;
                                    rom_addr   <= '0;
                                    fetch_wait <= 1'b0;
                                    state      <= S_FETCH;
                                end else if (retry_cnt < 8'(MAX_RETRY)) begin
                                    retry_cnt <= retry_cnt + 8'd1;
                                    tmr       <= '0;
                                    state     <= S_RETRY;
                                end else begin
                                    init_err  <= 1'b1;
                                    err_index <= '1;
                                    iic.w_r   <= 1'b1;
                                    state     <= S_ERROR;
                                end
                            end
                            S_EXEC: begin
                                if (iic.w_r || iic.data_out == exp_data) begin
                                    if (last_idx) begin
                                        init_over <= 1'b1;
                                        tmr       <= '0;
                                        state     <= S_DONE;
                                    end else begin
                                        rom_addr   <= rom_addr + 1'b1;
                                        fetch_wait <= 1'b0;
                                        state      <= S_FETCH;
                                    end
                                end else begin
                                    init_err  <= 1'b1;
                                    err_index <= rom_addr;
                                    iic.w_r   <= 1'b1;
                                    state     <= S_ERROR;
                                end
                            end
                            default: begin
                                // Poll completion; a start seen during the poll is honoured now.
                                poll_data  <= iic.data_out;
                                poll_valid <= 1'b1;
                                iic.w_r    <= 1'b1;
                                tmr        <= '0;
                                if (start || start_pend) begin
                                    state      <= S_IDLE;
                                    run_req    <= 1'b1;
                                    init_over  <= 1'b0;
                                    init_err   <= 1'b0;
                                    err_index  <= '0;
                                    rom_addr   <= '0;
                                    start_pend <= 1'b0;
                                end else begin
                                    state <= S_DONE;
                                end
                            end
                        endcase
                    end else if (tmr == TMO_LAST) begin
                        issued    <= 1'b0;
                        init_err  <= 1'b1;
                        err_index <= probe_phase ? '1 : rom_addr;
                        iic.w_r   <= 1'b1;
                        state     <= S_ERROR;
                    end else begin
                        tmr <= tmr + 32'd1;
                    end
                end

                S_RETRY: begin
                    if (tmr >= RETRY_LAST) begin
                        iic.addr    <= PROBE_ADDR;
                        iic.data_in <= PROBE_DATA;
                        iic.w_r     <= 1'b1;
                        issued      <= 1'b0;
                        state       <= S_PROBE_W;
                    end else begin
                        tmr <= tmr + 32'd1;
                    end
                end

                // First cycle covers the ROM read latency; decode on the second.
                S_FETCH: begin
                    if (!fetch_wait) begin
                        fetch_wait <= 1'b1;
                    end else begin
                        fetch_wait <= 1'b0;
                        exp_data   <= r_data;
                        if (op == OP_WRITE || op == OP_VERIFY) begin
                            iic.addr    <= r_addr;
                            iic.data_in <= r_data;
                            iic.w_r     <= (op == OP_WRITE);
                            issued      <= 1'b0;
                            state       <= S_EXEC;
                        end else if (op == OP_DELAY) begin
                            if ({r_addr, r_data} == '0) begin
                                if (last_idx) begin
                                    init_over <= 1'b1;
                                    tmr       <= '0;
                                    state     <= S_DONE;
                                end else begin
                                    rom_addr <= rom_addr + 1'b1;
                                    state    <= S_FETCH;
                                end
                            end else begin
                                dly_left <= {r_addr, r_data};
                                tmr      <= '0;
                                state    <= S_DELAY;
                            end
                        end else begin
                            init_over <= 1'b1;
                            tmr       <= '0;
                            state     <= S_DONE;
                        end
                    end
                end

                // Two-level count avoids a wide {addr,data}*DLY_UNIT product.
                S_DELAY: begin
                    if (tmr >= DLY_LAST) begin
                        tmr <= '0;
                        if (dly_left <= 1) begin
                            if (last_idx) begin
                                init_over <= 1'b1;
                                state     <= S_DONE;
                            end else begin
                                rom_addr   <= rom_addr + 1'b1;
                                fetch_wait <= 1'b0;
                                state      <= S_FETCH;
                            end
                        end else begin
                            dly_left <= dly_left - 1'b1;
                        end
                    end else begin
                        tmr <= tmr + 32'd1;
                    end
                end

                S_DONE: begin
                    if (start) begin
                        state      <= S_IDLE;
                        run_req    <= 1'b1;
                        init_over  <= 1'b0;
                        init_err   <= 1'b0;
                        err_index  <= '0;
                        rom_addr   <= '0;
                        start_pend <= 1'b0;
                        iic.w_r    <= 1'b1;
                    end else if (POLL_PERIOD > 0) begin
                        if (tmr >= POLL_LAST) begin
                            iic.addr <= POLL_ADDR;
                            iic.w_r  <= 1'b0;
                            issued   <= 1'b0;
                            state    <= S_POLL;
                        end else begin
                            tmr <= tmr + 32'd1;
                        end
                    end
                end

                default: begin
                    iic.w_r <= 1'b1;
                    if (start) begin
                        state      <= S_IDLE;
                        run_req    <= 1'b1;
                        init_over  <= 1'b0;
                        init_err   <= 1'b0;
                        err_index  <= '0;
                        rom_addr   <= '0;
                        start_pend <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
